trig_burst_gen: RTL

Trigger pulse-train generator that sits directly downstream of the ISA decoder. It takes the decoder's trigger request, pulse count and pulse step, and emits a burst of fixed-width trigger pulses on the 125 MHz system clock. Its output drives the star-trigger fan-out buffers. Status outputs report busy, burst completion and pulses issued.

---
 rtl/trig_burst_gen.sv | 136 +++++++++++++
 1 files changed

// File: rtl/trig_burst_gen.sv
// Trigger pulse-train generator: on a synchronised rising edge of I_Trig_in it emits
// I_Trig_Num pulses of PULSE_W cycles, spaced max(I_Trig_Step, PULSE_W+1) cycles apart.
//
// state  | meaning
// S_IDLE | waiting for a trigger rise; O_Done may pulse here for one cycle
// S_HIGH | O_Trig high, phase counter times the PULSE_W high time
// S_LOW  | O_Trig low, phase counter times the gap to the next rising edge
module trig_burst_gen #(
    parameter int PULSE_W = 4,
    parameter int CNT_W   = 32
) (
    input  logic             I_clk_125mhz,
    input  logic             I_Rst_n,
    input  logic             I_Trig_in,
    input  logic [CNT_W-1:0] I_Trig_Num,
    input  logic [CNT_W-1:0] I_Trig_Step,
    input  logic             I_Abort,
    output logic             O_Trig,
    output logic             O_Busy,
    output logic             O_Done,
    output logic [CNT_W-1:0] O_Pulse_Cnt
);

    localparam logic [CNT_W-1:0] C_STEP_MIN  = CNT_W'(PULSE_W + 1);
    localparam logic [CNT_W-1:0] C_HIGH_LAST = CNT_W'(PULSE_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HIGH,
        S_LOW
    } state_t;

    state_t           r_state;
    logic             r_s1;
    logic             r_s2;
    logic             r_s3;
    logic             r_trig;
    logic             r_busy;
    logic             r_done;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_num;
    logic [CNT_W-1:0] r_step;
    logic [CNT_W-1:0] r_phase;

    logic             w_rise;
    logic [CNT_W-1:0] w_step_eff;
    logic [CNT_W-1:0] w_low_last;

    assign w_rise     = r_s2 & ~r_s3;
    // Clamping the step keeps at least one low cycle between pulses.
    assign w_step_eff = (I_Trig_Step < C_STEP_MIN) ? C_STEP_MIN : I_Trig_Step;
    // Low phase lasts step - PULSE_W cycles; the down-counter ends at zero.
    assign w_low_last = r_step - C_STEP_MIN;

    always_ff @(posedge I_clk_125mhz or negedge I_Rst_n) begin
        if (!I_Rst_n) begin
            r_state <= S_IDLE;
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_s3    <= 1'b0;
            r_trig  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_cnt   <= '0;
            r_num   <= '0;
            r_step  <= '0;
            r_phase <= '0;
        end else begin
            r_s1   <= I_Trig_in;
            r_s2   <= r_s1;
            r_s3   <= r_s2;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // A rise coinciding with O_Done is dropped so bursts never chain.
                    if (w_rise && !r_done && !I_Abort) begin
                        r_num  <= I_Trig_Num;
                        r_step <= w_step_eff;
                        if (I_Trig_Num == '0) begin
                            r_done <= 1'b1;
                            r_cnt  <= '0;
                        end else begin
                            r_state <= S_HIGH;
                            r_trig  <= 1'b1;
                            r_busy  <= 1'b1;
                            r_cnt   <= CNT_W'(1);
                            r_phase <= C_HIGH_LAST;
                        end
                    end
                end
                S_HIGH: begin
                    if (I_Abort) begin
                        r_state <= S_IDLE;
                        r_trig  <= 1'b0;
                        r_busy  <= 1'b0;
                    end else if (r_phase != '0) begin
                        r_phase <= r_phase - 1'b1;
                    end else if (r_cnt == r_num) begin
                        r_state <= S_IDLE;
                        r_trig  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= S_LOW;
                        r_trig  <= 1'b0;
                        r_phase <= w_low_last;
                    end
                end
                S_LOW: begin
                    if (I_Abort) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_phase != '0) begin
                        r_phase <= r_phase - 1'b1;
                    end else begin
                        r_state <= S_HIGH;
                        r_trig  <= 1'b1;
                        r_cnt   <= r_cnt + 1'b1;
                        r_phase <= C_HIGH_LAST;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_trig  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign O_Trig      = r_trig;
    assign O_Busy      = r_busy;
    assign O_Done      = r_done;
    assign O_Pulse_Cnt = r_cnt;

endmodule
